// File: rtl/mcycle_controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode/extension
// values, condition codes, PSR bit positions and datapath mux select codes.
package mcycle_controller_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_LATCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_EX      = 4'd3,
        ST_WB      = 4'd4,
        ST_MOV_WB  = 4'd5,
        ST_MOVI_WB = 4'd6,
        ST_LD_ADDR = 4'd7,
        ST_LD_WB   = 4'd8,
        ST_ST      = 4'd9,
        ST_JMP     = 4'd10,
        ST_BR      = 4'd11
    } state_t;

    // Opcodes; ALU extension codes reuse the immediate-form opcode values
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_AND   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_MEMJ  = 4'b0100;
    localparam logic [3:0] OP_ADD   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_CMP   = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_MOVI  = 4'b1101;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JCOND = 4'b1100;
    localparam logic [3:0] EXT_MOV   = 4'b1101;

    localparam logic [3:0] CC_EQ = 4'd0,  CC_NE = 4'd1,  CC_CS = 4'd2,  CC_CC = 4'd3;
    localparam logic [3:0] CC_HI = 4'd4,  CC_LS = 4'd5,  CC_GT = 4'd6,  CC_LE = 4'd7;
    localparam logic [3:0] CC_FS = 4'd8,  CC_FC = 4'd9,  CC_LO = 4'd10, CC_HS = 4'd11;
    localparam logic [3:0] CC_LT = 4'd12, CC_GE = 4'd13, CC_UC = 4'd14, CC_NV = 4'd15;

    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    localparam logic [1:0] WD_IMM  = 2'b00, WD_RSRC = 2'b01, WD_MEM = 2'b10, WD_ALU = 2'b11;
    localparam logic [1:0] ALUA_RSRC = 2'b00, ALUA_PC = 2'b01, ALUA_IMM = 2'b10;
    localparam logic [1:0] ALUB_RDEST = 2'b00, ALUB_IMM = 2'b01, ALUB_ONE = 2'b10;

    function automatic logic is_alu_code(input logic [3:0] c);
        return c inside {OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR};
    endfunction

    // Arithmetic ops update flags and sign-extend their immediates
    function automatic logic is_arith_code(input logic [3:0] c);
        return c inside {OP_ADD, OP_SUB, OP_CMP};
    endfunction

endpackage

// File: rtl/mcycle_controller_cond_check.sv
// Branch/jump condition evaluation from the condition field and registered PSR.
module mcycle_controller_cond_check
    import mcycle_controller_pkg::*;
#(
    parameter int REG_ADD = 4,
    parameter int PSRL    = 5
) (
    input  logic [REG_ADD-1:0] Rdest_addr,
    input  logic [PSRL-1:0]    PSR_OUT,
    output logic               take
);
    logic w_n, w_z, w_f, w_l, w_c;

    assign w_n = PSR_OUT[PSR_N];
    assign w_z = PSR_OUT[PSR_Z];
    assign w_f = PSR_OUT[PSR_F];
    assign w_l = PSR_OUT[PSR_L];
    assign w_c = PSR_OUT[PSR_C];

    always_comb begin
        take = 1'b0;
        case (Rdest_addr[3:0])
            CC_EQ: take = w_z;
            CC_NE: take = !w_z;
            CC_CS: take = w_c;
            CC_CC: take = !w_c;
            CC_HI: take = w_l;
            CC_LS: take = !w_l;
            CC_GT: take = w_n;
            CC_LE: take = !w_n;
            CC_FS: take = w_f;
            CC_FC: take = !w_f;
            CC_LO: take = !w_l && !w_z;
            CC_HS: take = w_l || w_z;
            CC_LT: take = !w_n && !w_z;
            CC_GE: take = w_n || w_z;
            CC_UC: take = 1'b1;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/mcycle_controller.sv
// Multicycle control FSM for the 16-bit CPU: fetch/decode/execute/writeback
// sequencing and every datapath select, enable and write strobe.
module mcycle_controller
    import mcycle_controller_pkg::*;
#(
    parameter int REG_ADD   = 4,
    parameter int PSRL      = 5,
    parameter int STATEBITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_ADD-1:0]   OP_CODE,
    input  logic [REG_ADD-1:0]   OP_EXT,
    input  logic [REG_ADD-1:0]   Rdest_addr,
    input  logic [PSRL-1:0]      PSR_OUT,
    output logic                 PC_S,
    output logic                 MEM_S,
    output logic [1:0]           WD_S,
    output logic [1:0]           ALUA_S,
    output logic [1:0]           ALUB_S,
    output logic                 INSTR_EN,
    output logic                 ALU_OUT_EN,
    output logic                 MEM_REG_EN,
    output logic                 PC_EN,
    output logic                 PSR_EN,
    output logic                 SE_SIGN,
    output logic                 REG_WR,
    output logic                 MEM_WE,
    output logic                 ALU_FORCE_ADD,
    output logic                 ILLEGAL,
    output logic [STATEBITS-1:0] STATE
);
    state_t     r_state;
    state_t     w_dec_state;
    logic       w_take;
    logic [3:0] w_op, w_ext, w_code;
    logic       w_imm;

    assign w_op   = OP_CODE[3:0];
    assign w_ext  = OP_EXT[3:0];
    assign w_imm  = (w_op != OP_RTYPE);
    assign w_code = w_imm ? w_op : w_ext;

    mcycle_controller_cond_check #(.REG_ADD(REG_ADD), .PSRL(PSRL)) u_cond (
        .Rdest_addr (Rdest_addr),
        .PSR_OUT    (PSR_OUT),
        .take       (w_take)
    );

    always_comb begin
        w_dec_state = ST_FETCH;
        if (is_alu_code(w_code))                          w_dec_state = ST_EX;
        else if (!w_imm && w_ext == EXT_MOV)              w_dec_state = ST_MOV_WB;
        else if (w_op == OP_MOVI)                         w_dec_state = ST_MOVI_WB;
        else if (w_op == OP_MEMJ && w_ext == EXT_LOAD)    w_dec_state = ST_LD_ADDR;
        else if (w_op == OP_MEMJ && w_ext == EXT_STOR)    w_dec_state = ST_ST;
        else if (w_op == OP_MEMJ && w_ext == EXT_JCOND)   w_dec_state = ST_JMP;
        else if (w_op == OP_BCOND)                        w_dec_state = ST_BR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH:   r_state <= ST_LATCH;
                ST_LATCH:   r_state <= ST_DECODE;
                ST_DECODE:  r_state <= w_dec_state;
                ST_EX:      r_state <= (w_code == OP_CMP) ? ST_FETCH : ST_WB;
                ST_LD_ADDR: r_state <= ST_LD_WB;
                default:    r_state <= ST_FETCH;
            endcase
        end
    end

    // Outputs decode the current state; reset forces everything low, MEM_S included
    always_comb begin
        PC_S = 1'b0; MEM_S = 1'b0; WD_S = WD_IMM; ALUA_S = ALUA_RSRC; ALUB_S = ALUB_RDEST;
        INSTR_EN = 1'b0; ALU_OUT_EN = 1'b0; MEM_REG_EN = 1'b0; PC_EN = 1'b0; PSR_EN = 1'b0;
        SE_SIGN = 1'b0; REG_WR = 1'b0; MEM_WE = 1'b0; ALU_FORCE_ADD = 1'b0; ILLEGAL = 1'b0;
        STATE = '0;
        if (reset) begin
            STATE = STATEBITS'(r_state);
            case (r_state)
                ST_FETCH: MEM_S = 1'b1;
                ST_LATCH: begin
                    MEM_S = 1'b1; INSTR_EN = 1'b1; PC_EN = 1'b1; PC_S = 1'b1;
                    ALUA_S = ALUA_PC; ALUB_S = ALUB_ONE; ALU_FORCE_ADD = 1'b1;
                end
                ST_DECODE: ILLEGAL = (w_dec_state == ST_FETCH);
                ST_EX: begin
                    ALU_OUT_EN = 1'b1;
                    ALUB_S     = w_imm ? ALUB_IMM : ALUB_RDEST;
                    PSR_EN     = is_arith_code(w_code);
                    SE_SIGN    = w_imm && is_arith_code(w_code);
                end
                ST_WB:      begin WD_S = WD_ALU;  REG_WR = 1'b1; end
                ST_MOV_WB:  begin WD_S = WD_RSRC; REG_WR = 1'b1; end
                ST_MOVI_WB: begin WD_S = WD_IMM;  REG_WR = 1'b1; end
                ST_LD_WB:   begin MEM_REG_EN = 1'b1; WD_S = WD_MEM; REG_WR = 1'b1; end
                ST_ST:      MEM_WE = 1'b1;
                ST_JMP:     PC_EN = w_take;
                ST_BR: if (w_take) begin
                    ALUA_S = ALUA_PC; ALUB_S = ALUB_IMM; SE_SIGN = 1'b1;
                    ALU_FORCE_ADD = 1'b1; PC_S = 1'b1; PC_EN = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle_controller.sv
// Bench for mcycle_controller: condition table, directed corner sequences and
// random instructions checked against an instruction-level timeline model.
module tb_mcycle_controller;
    import mcycle_controller_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] OP_CODE = '0, OP_EXT = '0, Rdest_addr = '0;
    logic [4:0] PSR_OUT = '0;
    logic       PC_S, MEM_S, INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN, PSR_EN;
    logic       SE_SIGN, REG_WR, MEM_WE, ALU_FORCE_ADD, ILLEGAL;
    logic [1:0] WD_S, ALUA_S, ALUB_S;
    logic [3:0] STATE;

    mcycle_controller #(.REG_ADD(4), .PSRL(5), .STATEBITS(4)) dut (
        .clk(clk), .reset(reset), .OP_CODE(OP_CODE), .OP_EXT(OP_EXT),
        .Rdest_addr(Rdest_addr), .PSR_OUT(PSR_OUT), .PC_S(PC_S), .MEM_S(MEM_S),
        .WD_S(WD_S), .ALUA_S(ALUA_S), .ALUB_S(ALUB_S), .INSTR_EN(INSTR_EN),
        .ALU_OUT_EN(ALU_OUT_EN), .MEM_REG_EN(MEM_REG_EN), .PC_EN(PC_EN),
        .PSR_EN(PSR_EN), .SE_SIGN(SE_SIGN), .REG_WR(REG_WR), .MEM_WE(MEM_WE),
        .ALU_FORCE_ADD(ALU_FORCE_ADD), .ILLEGAL(ILLEGAL), .STATE(STATE)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_s, mem_s;
        logic [1:0] wd_s, alua_s, alub_s;
        logic       instr_en, alu_out_en, mem_reg_en, pc_en, psr_en;
        logic       se_sign, reg_wr, mem_we, force_add, illegal;
    } outv_t;

    typedef struct {
        logic [3:0] cc;
        logic [4:0] psr;   // {N,Z,F,L,C}
        logic       take;
    } cond_vec_t;

    int    n_chk = 0;
    int    n_fail = 0;
    outv_t exp_q[$];

    function automatic outv_t get_act();
        outv_t a;
        a = '{PC_S, MEM_S, WD_S, ALUA_S, ALUB_S, INSTR_EN, ALU_OUT_EN, MEM_REG_EN,
              PC_EN, PSR_EN, SE_SIGN, REG_WR, MEM_WE, ALU_FORCE_ADD, ILLEGAL};
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Condition evaluation straight from the mnemonic table
    function automatic logic ref_cond(input logic [3:0] cc, input logic [4:0] psr);
        logic n, z, f, l, c;
        {n, z, f, l, c} = psr;
        case (cc)
            0: return z;       1: return !z;      2: return c;        3: return !c;
            4: return l;       5: return !l;      6: return n;        7: return !n;
            8: return f;       9: return !f;      10: return !l && !z; 11: return l || z;
            12: return !n && !z; 13: return n || z; 14: return 1'b1;   default: return 1'b0;
        endcase
    endfunction

    // Per-cycle expected outputs for one whole instruction, fetch to last cycle
    task automatic model(input logic [3:0] op, input logic [3:0] ext,
                         input logic [3:0] rd, input logic [4:0] psr);
        outv_t v;
        logic  rr, ri, arith, tk;
        logic [3:0] fn;
        rr = (op == 4'd0) && (ext inside {4'd5, 4'd9, 4'd11, 4'd1, 4'd2, 4'd3});
        ri = op inside {4'd5, 4'd9, 4'd11, 4'd1, 4'd2, 4'd3};
        fn = rr ? ext : op;
        arith = fn inside {4'd5, 4'd9, 4'd11};
        tk = ref_cond(rd, psr);
        exp_q.delete();
        v = '0; v.mem_s = 1; exp_q.push_back(v);
        v = '0; v.mem_s = 1; v.instr_en = 1; v.pc_en = 1; v.pc_s = 1;
        v.alua_s = 2'b01; v.alub_s = 2'b10; v.force_add = 1; exp_q.push_back(v);
        v = '0;
        v.illegal = !(rr || ri || (op == 0 && ext == 13) || op == 13 || op == 12 ||
                      (op == 4 && ext inside {4'd0, 4'd4, 4'd12}));
        exp_q.push_back(v);
        if (rr || ri) begin
            v = '0; v.alu_out_en = 1; v.alub_s = ri ? 2'b01 : 2'b00;
            v.psr_en = arith; v.se_sign = ri && arith; exp_q.push_back(v);
            if (fn != 4'd11) begin v = '0; v.wd_s = 2'b11; v.reg_wr = 1; exp_q.push_back(v); end
        end else if (op == 0 && ext == 13) begin
            v = '0; v.wd_s = 2'b01; v.reg_wr = 1; exp_q.push_back(v);
        end else if (op == 13) begin
            v = '0; v.wd_s = 2'b00; v.reg_wr = 1; exp_q.push_back(v);
        end else if (op == 4 && ext == 0) begin
            v = '0; exp_q.push_back(v);
            v = '0; v.mem_reg_en = 1; v.wd_s = 2'b10; v.reg_wr = 1; exp_q.push_back(v);
        end else if (op == 4 && ext == 4) begin
            v = '0; v.mem_we = 1; exp_q.push_back(v);
        end else if (op == 4 && ext == 12) begin
            v = '0; v.pc_en = tk; exp_q.push_back(v);
        end else if (op == 12) begin
            v = '0;
            if (tk) begin
                v.alua_s = 2'b01; v.alub_s = 2'b01; v.se_sign = 1;
                v.force_add = 1; v.pc_s = 1; v.pc_en = 1;
            end
            exp_q.push_back(v);
        end
    endtask

    // Entered just after a posedge with the DUT in FETCH; leaves the same way
    task automatic run_instr(input logic [3:0] op, input logic [3:0] ext,
                             input logic [3:0] rd, input logic [4:0] psr, input string tag);
        OP_CODE = op; OP_EXT = ext; Rdest_addr = rd; PSR_OUT = psr;
        model(op, ext, rd, psr);
        foreach (exp_q[i]) begin
            @(negedge clk);
            chk($sformatf("%s op=%h ext=%h cyc%0d", tag, op, ext, i), 32'(get_act()), 32'(exp_q[i]));
            if (i == 0) chk($sformatf("%s state_fetch", tag), 32'(STATE), 32'(ST_FETCH));
            if (i == 1) chk($sformatf("%s state_latch", tag), 32'(STATE), 32'(ST_LATCH));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        cond_vec_t tbl[] = '{
            '{4'd0,  5'b01000, 1'b1}, '{4'd0,  5'b00000, 1'b0}, '{4'd1,  5'b00000, 1'b1},
            '{4'd1,  5'b01000, 1'b0}, '{4'd2,  5'b00001, 1'b1}, '{4'd3,  5'b00001, 1'b0},
            '{4'd4,  5'b00010, 1'b1}, '{4'd5,  5'b00010, 1'b0}, '{4'd6,  5'b10000, 1'b1},
            '{4'd7,  5'b10000, 1'b0}, '{4'd8,  5'b00100, 1'b1}, '{4'd9,  5'b00000, 1'b1},
            '{4'd10, 5'b00000, 1'b1}, '{4'd10, 5'b00010, 1'b0}, '{4'd11, 5'b01000, 1'b1},
            '{4'd11, 5'b00000, 1'b0}, '{4'd12, 5'b00000, 1'b1}, '{4'd12, 5'b10000, 1'b0},
            '{4'd13, 5'b01000, 1'b1}, '{4'd13, 5'b00000, 1'b0}, '{4'd14, 5'b00000, 1'b1},
            '{4'd15, 5'b11111, 1'b0}
        };
        logic [3:0] alu_ext[6] = '{4'd5, 4'd9, 4'd11, 4'd1, 4'd2, 4'd3};
        logic [3:0] mj_ext[3]  = '{4'd0, 4'd4, 4'd12};

        // Reset held low for 3 cycles: every output low
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outs", 32'(get_act()), 32'd0);
            chk("reset_state", 32'(STATE), 32'd0);
        end
        @(posedge clk); #1 reset = 1'b1;

        run_instr(4'b0000, 4'b0101, 4'd2, 5'd0, "add");
        run_instr(4'b1011, 4'b0000, 4'd3, 5'd0, "cmpi");
        run_instr(4'b0100, 4'b0000, 4'd1, 5'd0, "load");
        run_instr(4'b0100, 4'b0100, 4'd1, 5'd0, "stor");
        run_instr(4'b1110, 4'b0000, 4'd0, 5'd0, "illegal");
        run_instr(4'b0000, 4'b0000, 4'd0, 5'd0, "illegal_rr");
        run_instr(4'b0100, 4'b0001, 4'd0, 5'd0, "illegal_mj");

        // Condition table through both Jcond and Bcond
        foreach (tbl[k]) begin
            OP_CODE = 4'b0100; OP_EXT = 4'b1100; Rdest_addr = tbl[k].cc; PSR_OUT = tbl[k].psr;
            repeat (4) @(negedge clk);
            chk($sformatf("jcond cc=%0d pc_en", tbl[k].cc), 32'(PC_EN), 32'(tbl[k].take));
            chk($sformatf("jcond cc=%0d pc_s", tbl[k].cc), 32'(PC_S), 32'd0);
            @(posedge clk); #1;
            OP_CODE = 4'b1100; OP_EXT = 4'b0000;
            repeat (4) @(negedge clk);
            chk($sformatf("bcond cc=%0d pc_en", tbl[k].cc), 32'(PC_EN), 32'(tbl[k].take));
            chk($sformatf("bcond cc=%0d alub", tbl[k].cc), 32'(ALUB_S), tbl[k].take ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end

        // Reset asserted in LD_WB kills the write at once
        OP_CODE = 4'b0100; OP_EXT = 4'b0000;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        chk("ldwb_reg_wr_before", 32'(REG_WR), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("ldwb_reset_outs", 32'(get_act()), 32'd0);
        chk("ldwb_reset_state", 32'(STATE), 32'd0);
        @(negedge clk);
        chk("ldwb_reset_hold", 32'(get_act()), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        run_instr(4'b0100, 4'b0100, 4'd0, 5'd0, "after_reset_stor");

        for (int n = 0; n < 250; n++) begin
            logic [3:0] op, ext;
            op  = 4'($urandom_range(0, 15));
            ext = 4'($urandom_range(0, 15));
            if (op == 0 && $urandom_range(0, 3) != 0) ext = alu_ext[$urandom_range(0, 5)];
            if (op == 0 && $urandom_range(0, 5) == 0) ext = 4'd13;
            if (op == 4 && $urandom_range(0, 3) != 0) ext = mj_ext[$urandom_range(0, 2)];
            run_instr(op, ext, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
